accelerator_erase_matrix: RTL

//  Multi-head successor of the DNC write-head erase stage: e(t;i;k) = sigmoid(e^(t;i;k)) for i in 0..R-1, k in 0..W-1.

---
 rtl/accelerator_dnc_pkg.sv | 58 +++++
 rtl/accelerator_plan_sigmoid.sv | 109 ++++++++++
 rtl/accelerator_erase_matrix.sv | 125 ++++++++++++
 3 files changed

// File: rtl/accelerator_dnc_pkg.sv
// Shared types and PLAN sigmoid constants for the DNC erase-stage accelerators.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package accelerator_dnc_pkg;

  // Job sequencing states of the erase-matrix controller.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // PLAN segment selectors, ordered by increasing |x|.
  localparam logic [1:0] SEG_LO  = 2'd0;  // |x| < 1
  localparam logic [1:0] SEG_MID = 2'd1;  // 1 <= |x| < 2.375
  localparam logic [1:0] SEG_HI  = 2'd2;  // 2.375 <= |x| < 5
  localparam logic [1:0] SEG_SAT = 2'd3;  // |x| >= 5

  // Wide enough for any datapath; callers truncate to their own width.
  typedef logic [127:0] plan_w_t;

  // 1.0 in Q(frac).
  function automatic plan_w_t plan_one(input int frac);
    return plan_w_t'(1) << frac;
  endfunction

  // 5.0: saturation breakpoint.
  function automatic plan_w_t plan_bp_sat(input int frac);
    return plan_w_t'(5) << frac;
  endfunction

  // 2.375 = 19/8: upper linear segment breakpoint.
  function automatic plan_w_t plan_bp_hi(input int frac);
    return plan_w_t'(19) << (frac - 3);
  endfunction

  // 1.0: middle linear segment breakpoint.
  function automatic plan_w_t plan_bp_mid(input int frac);
    return plan_w_t'(1) << frac;
  endfunction

  // 0.84375 = 27/32: offset of the upper segment.
  function automatic plan_w_t plan_off_hi(input int frac);
    return plan_w_t'(27) << (frac - 5);
  endfunction

  // 0.625 = 5/8: offset of the middle segment.
  function automatic plan_w_t plan_off_mid(input int frac);
    return plan_w_t'(5) << (frac - 3);
  endfunction

  // 0.5: offset of the lowest segment.
  function automatic plan_w_t plan_off_lo(input int frac);
    return plan_w_t'(1) << (frac - 1);
  endfunction

endpackage

// File: rtl/accelerator_plan_sigmoid.sv
// PLAN piecewise-linear sigmoid with (i,k) tag passthrough, shift/add only.
// Latency: 2 cycles from vld_i to vld_o; one element per cycle.
// Backpressure: none; gaps in vld_i appear as identical gaps on vld_o.
module accelerator_plan_sigmoid #(
  parameter int DATA_SIZE = 64,
  parameter int FRAC_SIZE = 32,
  parameter int TAG_SIZE  = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 vld_i,
  input  logic [DATA_SIZE-1:0] x_i,
  input  logic [TAG_SIZE-1:0]  i_i,
  input  logic [TAG_SIZE-1:0]  k_i,
  output logic                 vld_o,
  output logic [DATA_SIZE-1:0] y_o,
  output logic [TAG_SIZE-1:0]  i_o,
  output logic [TAG_SIZE-1:0]  k_o,
  output logic                 sat_o
);
  import accelerator_dnc_pkg::*;

  // One extra bit so |x| of any input is representable without wrap.
  localparam int AW = DATA_SIZE + 1;
  localparam logic [AW-1:0] ONE     = AW'(plan_one(FRAC_SIZE));
  localparam logic [AW-1:0] BP_SAT  = AW'(plan_bp_sat(FRAC_SIZE));
  localparam logic [AW-1:0] BP_HI   = AW'(plan_bp_hi(FRAC_SIZE));
  localparam logic [AW-1:0] BP_MID  = AW'(plan_bp_mid(FRAC_SIZE));
  localparam logic [AW-1:0] OFF_HI  = AW'(plan_off_hi(FRAC_SIZE));
  localparam logic [AW-1:0] OFF_MID = AW'(plan_off_mid(FRAC_SIZE));
  localparam logic [AW-1:0] OFF_LO  = AW'(plan_off_lo(FRAC_SIZE));
  localparam logic [DATA_SIZE-1:0] MOST_NEG = {1'b1, {(DATA_SIZE-1){1'b0}}};

  logic                 s1_vld_q, s1_neg_q;
  logic [AW-1:0]        s1_mag_q;
  logic [1:0]           s1_seg_q;
  logic [TAG_SIZE-1:0]  s1_i_q, s1_k_q;
  logic [AW-1:0]        mag_d, y_d, y_clamp, res_d;
  logic [1:0]           seg_d;

  // Stage 1 combinational: magnitude (most-negative pinned to max positive) and segment pick.
  always_comb begin
    mag_d = '0;
    if (x_i == MOST_NEG) begin
      mag_d = {2'b00, {(DATA_SIZE-1){1'b1}}};
    end else if (x_i[DATA_SIZE-1]) begin
      mag_d = -{x_i[DATA_SIZE-1], x_i};
    end else begin
      mag_d = {1'b0, x_i};
    end
    if (mag_d >= BP_SAT)      seg_d = SEG_SAT;
    else if (mag_d >= BP_HI)  seg_d = SEG_HI;
    else if (mag_d >= BP_MID) seg_d = SEG_MID;
    else                      seg_d = SEG_LO;
  end

  // Stage 1 registers: |x|, sign, segment and tag; data only loads on a valid element.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_vld_q <= 1'b0;
      s1_neg_q <= 1'b0;
      s1_mag_q <= '0;
      s1_seg_q <= SEG_LO;
      s1_i_q   <= '0;
      s1_k_q   <= '0;
    end else begin
      s1_vld_q <= vld_i;
      if (vld_i) begin
        s1_neg_q <= x_i[DATA_SIZE-1];
        s1_mag_q <= mag_d;
        s1_seg_q <= seg_d;
        s1_i_q   <= i_i;
        s1_k_q   <= k_i;
      end
    end
  end

  // Stage 2 combinational: segment shift+offset, clamp to ONE, then mirror for negative x.
  always_comb begin
    case (s1_seg_q)
      SEG_SAT: y_d = ONE;
      SEG_HI:  y_d = (s1_mag_q >> 5) + OFF_HI;
      SEG_MID: y_d = (s1_mag_q >> 3) + OFF_MID;
      default: y_d = (s1_mag_q >> 2) + OFF_LO;
    endcase
    y_clamp = (y_d > ONE) ? ONE : y_d;
    res_d   = s1_neg_q ? (ONE - y_clamp) : y_clamp;
  end

  // Stage 2 registers: outputs hold their last value while no element is valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_o <= 1'b0;
      y_o   <= '0;
      i_o   <= '0;
      k_o   <= '0;
      sat_o <= 1'b0;
    end else begin
      vld_o <= s1_vld_q;
      if (s1_vld_q) begin
        y_o   <= res_d[DATA_SIZE-1:0];
        i_o   <= s1_i_q;
        k_o   <= s1_k_q;
        sat_o <= (s1_seg_q == SEG_SAT);
      end
    end
  end

endmodule

// File: rtl/accelerator_erase_matrix.sv
// Multi-head DNC erase stage: streams R*W logits, emits sigmoid erase weights tagged (i,k).
// Latency: 2 cycles input to output; READY the cycle after the last output.
// Backpressure: none; optional SAT_COUNT port when ACCELERATOR_ERASE_MATRIX_STATUS_EN is defined.
module accelerator_erase_matrix #(
  parameter int DATA_SIZE    = 64,
  parameter int FRAC_SIZE    = 32,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic                    E_IN_ENABLE,
  output logic                    E_OUT_ENABLE,
  input  logic [CONTROL_SIZE-1:0] SIZE_R_IN,
  input  logic [CONTROL_SIZE-1:0] SIZE_W_IN,
  input  logic [DATA_SIZE-1:0]    E_IN,
  output logic [DATA_SIZE-1:0]    E_OUT,
  output logic [CONTROL_SIZE-1:0] I_OUT,
  output logic [CONTROL_SIZE-1:0] K_OUT
`ifdef ACCELERATOR_ERASE_MATRIX_STATUS_EN
  ,
  output logic [CONTROL_SIZE-1:0] SAT_COUNT
`endif
);
  import accelerator_dnc_pkg::*;

  state_e                  state_q, state_d;
  logic [CONTROL_SIZE-1:0] size_r_q, size_w_q;
  logic [CONTROL_SIZE-1:0] i_in_q, i_in_d, k_in_q, k_in_d;
  logic                    drain_q;
  logic                    start_ok, accept, last_in, out_sat;

  assign start_ok = (state_q == IDLE) && START;
  assign accept   = (state_q == RUN) && E_IN_ENABLE;
  assign last_in  = (i_in_q == size_r_q - 1'b1) && (k_in_q == size_w_q - 1'b1);
  assign READY    = (state_q == DONE);

  // Job sequencing; an empty job goes straight to DONE so READY still pulses once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (START) state_d = (SIZE_R_IN == '0 || SIZE_W_IN == '0) ? DONE : RUN;
      RUN:   if (accept && last_in) state_d = DRAIN;
      DRAIN: if (drain_q) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Head-major index counters: k inner, wraps at W-1 and bumps i.
  always_comb begin
    k_in_d = k_in_q;
    i_in_d = i_in_q;
    if (start_ok) begin
      k_in_d = '0;
      i_in_d = '0;
    end else if (accept) begin
      if (k_in_q == size_w_q - 1'b1) begin
        k_in_d = '0;
        i_in_d = i_in_q + 1'b1;
      end else begin
        k_in_d = k_in_q + 1'b1;
      end
    end
  end

  // State, size latches, counters; drain_q marks the second DRAIN cycle, when the last output is out.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      size_r_q <= '0;
      size_w_q <= '0;
      i_in_q   <= '0;
      k_in_q   <= '0;
      drain_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_in_q  <= i_in_d;
      k_in_q  <= k_in_d;
      drain_q <= (state_q == DRAIN) ? ~drain_q : 1'b0;
      if (start_ok) begin
        size_r_q <= SIZE_R_IN;
        size_w_q <= SIZE_W_IN;
      end
    end
  end

  accelerator_plan_sigmoid #(
    .DATA_SIZE (DATA_SIZE),
    .FRAC_SIZE (FRAC_SIZE),
    .TAG_SIZE  (CONTROL_SIZE)
  ) u_sigmoid (
    .clk_i  (CLK),
    .rst_ni (RST),
    .vld_i  (accept),
    .x_i    (E_IN),
    .i_i    (i_in_q),
    .k_i    (k_in_q),
    .vld_o  (E_OUT_ENABLE),
    .y_o    (E_OUT),
    .i_o    (I_OUT),
    .k_o    (K_OUT),
    .sat_o  (out_sat)
  );

`ifdef ACCELERATOR_ERASE_MATRIX_STATUS_EN
  logic [CONTROL_SIZE-1:0] sat_cnt_q;
  assign SAT_COUNT = sat_cnt_q;

  // Saturated-output counter; no outputs arrive between READY and the next START, so it stays put.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sat_cnt_q <= '0;
    end else if (start_ok) begin
      sat_cnt_q <= '0;
    end else if (E_OUT_ENABLE && out_sat) begin
      sat_cnt_q <= sat_cnt_q + 1'b1;
    end
  end
`else
  logic sat_unused;
  assign sat_unused = out_sat;
`endif

endmodule
